// File: rtl/des_pkg.sv
// Shared DES constants and types for the round engine: expansion, permutation and S-box tables.
// Table entries use 0-based DES bit numbering (bit 0 = MSB).
package des_pkg;

    typedef logic [0:31] half_t;
    typedef logic [0:47] subkey_t;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [4:0] E_TAB [48] = '{
        31,  0,  1,  2,  3,  4,  3,  4,  5,  6,  7,  8,
         7,  8,  9, 10, 11, 12, 11, 12, 13, 14, 15, 16,
        15, 16, 17, 18, 19, 20, 19, 20, 21, 22, 23, 24,
        23, 24, 25, 26, 27, 28, 27, 28, 29, 30, 31,  0
    };

    localparam logic [4:0] P_TAB [32] = '{
        15,  6, 19, 20, 28, 11, 27, 16,  0, 14, 22, 25,  4, 17, 30,  9,
         1,  7, 23, 13, 31, 26,  2,  8, 18, 12, 29,  5, 21, 10,  3, 24
    };

    // Each box is flattened row-major: index = row*16 + column.
    localparam logic [3:0] SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

endpackage

// File: rtl/des_feistel.sv
// DES round function f(R, K): expand, key mix, S-box substitution, P permutation.
// Purely combinational; the round engine reuses the single instance every round.
module des_feistel
    import des_pkg::*;
(
    input  half_t   i_r,
    input  subkey_t i_subkey,
    output half_t   o_f
);

    subkey_t w_x;
    half_t   w_s;

    generate
        for (genvar gi = 0; gi < 48; gi++) begin : g_expand
            assign w_x[gi] = i_r[E_TAB[gi]] ^ i_subkey[gi];
        end

        // Outer bits of each 6-bit group select the row, inner four the column.
        for (genvar gi = 0; gi < 8; gi++) begin : g_sbox
            logic [5:0] w_grp;
            assign w_grp           = w_x[gi*6 +: 6];
            assign w_s[gi*4 +: 4]  = SBOX[gi][{w_grp[5], w_grp[0], w_grp[4:1]}];
        end

        for (genvar gi = 0; gi < 32; gi++) begin : g_perm
            assign o_f[gi] = w_s[P_TAB[gi]];
        end
    endgenerate

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES Feistel core: one round per clock between the IP and FP stages,
// with valid/ready handshakes on both sides and subkeys fetched by round index.
module des_round_engine
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
)
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:63] in_block,
    input  logic        decrypt,
    output logic [3:0]  key_round,
    input  logic [0:47] subkey,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] out_block
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

    state_t      r_state;
    half_t       r_l;
    half_t       r_r;
    logic [3:0]  r_rnd;
    logic        r_dir;
    half_t       w_f;

    des_feistel u_feistel (
        .i_r      (r_r),
        .i_subkey (subkey),
        .o_f      (w_f)
    );

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_block = (r_state == DONE) ? {r_r, r_l} : '0;
    // Decryption walks the same schedule backwards.
    assign key_round = (r_state != ROUND) ? 4'd0 :
                       (r_dir ? (4'd15 - r_rnd) : r_rnd);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_l     <= '0;
            r_r     <= '0;
            r_rnd   <= '0;
            r_dir   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_l     <= in_block[0:31];
                        r_r     <= in_block[32:63];
                        r_dir   <= decrypt;
                        r_rnd   <= '0;
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    r_l   <= r_r;
                    r_r   <= r_l ^ w_f;
                    r_rnd <= r_rnd + 4'd1;
                    if (r_rnd == LAST_RND) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_engine.sv
// Self-checking bench for des_round_engine: FIPS vectors, handshake corner cases and
// randomized blocks against a table-driven DES reference model with its own key schedule.
module tb_des_round_engine;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        in_valid;
    logic        in_ready;
    logic [0:63] in_block;
    logic        decrypt;
    logic [3:0]  key_round;
    logic [0:47] subkey;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] out_block;

    int n_checks = 0;
    int n_fail   = 0;
    bit fips_key = 1'b0;

    logic [47:0] ks [16];

    always #5 clk = ~clk;

    assign subkey = ks[key_round];

    des_round_engine #(.NUM_ROUNDS(16)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .decrypt   (decrypt),
        .key_round (key_round),
        .subkey    (subkey),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block)
    );

    // Standard DES tables in the usual 1-based notation.
    localparam int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                                16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                  41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SB [8][4][16] = '{
        '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
          '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
        '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
          '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
        '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
          '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
        '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
          '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
        '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
          '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
        '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
          '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
        '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
          '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
        '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
          '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
    };

    localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] FIPS_IP  = 64'hCC00CCFFF0AAF0AA;
    localparam logic [63:0] FIPS_PRE = 64'h0A4CD99543423234;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference key schedule: PC1, per-round left rotations of C and D, PC2.
    task automatic set_key(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c, d;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int rd = 0; rd < 16; rd++) begin
            for (int s = 0; s < SHIFT_T[rd]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[rd][47-i] = cd[56-PC2_T[i]];
        end
    endtask

    function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s, p;
        logic [5:0]  six;
        int row, col;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            row = 2 * int'(six[5]) + int'(six[0]);
            col = int'(six[4:1]);
            s[31-4*b -: 4] = 4'(SB[b][row][col]);
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
        return p;
    endfunction

    function automatic logic [63:0] des_model(input logic [63:0] blk, input logic dec);
        logic [31:0] l, r, t;
        l = blk[63:32];
        r = blk[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ f_model(r, dec ? ks[15-i] : ks[i]);
            l = t;
        end
        return {r, l};
    endfunction

    // One transaction, entered and left on a falling edge with the engine idle.
    task automatic run_block(input logic [63:0] blk, input logic dec, input logic [63:0] exp,
                             input int bp, input int poke_at, input int abort_at);
        check("idle_ready", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_block  = blk;
        decrypt   = dec;
        out_ready = (bp == 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_block = {$urandom, $urandom};
        decrypt  = ~dec;
        for (int i = 0; i < 16; i++) begin
            if (i == abort_at) begin
                n_rst = 1'b0;
                #1;
                check("rst_valid", 64'(out_valid), 64'd0);
                check("rst_ready", 64'(in_ready), 64'd1);
                check("rst_keyrnd", 64'(key_round), 64'd0);
                @(negedge clk);
                n_rst = 1'b1;
                $display("block %h dec=%0d aborted by reset at round %0d", blk, dec, i);
                return;
            end
            check("key_round", 64'(key_round), 64'(dec ? 15 - i : i));
            check("busy_ready", 64'(in_ready), 64'd0);
            check("early_valid", 64'(out_valid), 64'd0);
            if (i == 0 && fips_key && !dec) check("subkey1", 64'(subkey), 64'h1B02EFFC7072);
            if (i == poke_at) begin
                in_valid = 1'b1;
                in_block = {$urandom, $urandom};
            end else if (i == poke_at + 1) begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("out_valid", 64'(out_valid), 64'd1);
        check("out_block", out_block, exp);
        for (int j = 0; j < bp; j++) begin
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_block", out_block, exp);
            check("hold_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("ret_ready", 64'(in_ready), 64'd1);
        check("ret_valid", 64'(out_valid), 64'd0);
        $display("block %h dec=%0d bp=%0d poke=%0d -> expected %h", blk, dec, bp, poke_at, exp);
    endtask

    initial begin
        logic [63:0] blk_b, exp_b, blk;
        logic        dec;
        n_rst     = 1'b0;
        in_valid  = 1'b0;
        in_block  = '0;
        decrypt   = 1'b0;
        out_ready = 1'b0;
        set_key(FIPS_KEY);
        repeat (2) @(negedge clk);
        check("reset_ready", 64'(in_ready), 64'd1);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_block", out_block, 64'd0);
        check("reset_keyrnd", 64'(key_round), 64'd0);
        n_rst = 1'b1;
        @(negedge clk);

        fips_key = 1'b1;
        run_block(FIPS_IP,  1'b0, FIPS_PRE, 0,  -1, -1);
        run_block(FIPS_PRE, 1'b1, FIPS_IP,  0,  -1, -1);
        run_block(FIPS_IP,  1'b0, FIPS_PRE, 10, -1, -1);
        run_block(FIPS_IP,  1'b0, FIPS_PRE, 0,   5, -1);
        run_block(FIPS_IP,  1'b0, FIPS_PRE, 0,  -1,  8);
        run_block(FIPS_IP,  1'b0, FIPS_PRE, 0,  -1, -1);

        // Back-to-back: in_valid stays high across the whole first block.
        blk_b     = {$urandom, $urandom};
        exp_b     = des_model(blk_b, 1'b1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_block  = FIPS_IP;
        decrypt   = 1'b0;
        @(negedge clk);
        in_block = blk_b;
        decrypt  = 1'b1;
        repeat (16) @(negedge clk);
        check("b2b_valid_a", 64'(out_valid), 64'd1);
        check("b2b_block_a", out_block, FIPS_PRE);
        @(negedge clk);
        check("b2b_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_accept", 64'(in_ready), 64'd0);
        repeat (16) @(negedge clk);
        check("b2b_valid_b", 64'(out_valid), 64'd1);
        check("b2b_block_b", out_block, exp_b);
        @(negedge clk);
        check("b2b_idle", 64'(in_ready), 64'd1);
        $display("back-to-back %h then %h -> expected %h, %h", FIPS_IP, blk_b, FIPS_PRE, exp_b);

        fips_key = 1'b0;
        for (int t = 0; t < 24; t++) begin
            if (t % 6 == 0) set_key({$urandom, $urandom});
            blk = {$urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            run_block(blk, dec, des_model(blk, dec), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
